// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe: binary index to one-hot decoder behind a 2-entry valid/ready FIFO.
// Define ONEHOT_DECODER_PIPE_ERR_EN to store and report a per-entry out-of-range flag.
module onehot_decoder_pipe #(
    parameter int INPUT_W  = 3,
    parameter int OUTPUT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [INPUT_W-1:0]  in_idx,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUTPUT_W-1:0] out_onehot,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready
);
    logic [OUTPUT_W-1:0] mem [2];
    logic [OUTPUT_W-1:0] dec;
    logic [1:0]          count;
    logic                wr_ptr, rd_ptr, push, pop;

    assign in_ready  = count != 2'd2;
    assign out_valid = count != 2'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_onehot = out_valid ? mem[rd_ptr] : '0;

    // Out-of-range indices match no bit, so they decode to all zeros.
    always_comb begin
        dec = '0;
        for (int i = 0; i < OUTPUT_W; i++) dec[i] = 32'(in_idx) == i;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            count  <= count + 2'(push) - 2'(pop);
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
        end
    end

    always_ff @(posedge clk) if (push) mem[wr_ptr] <= dec;

`ifdef ONEHOT_DECODER_PIPE_ERR_EN
    logic err_mem [2];

    always_ff @(posedge clk) if (push) err_mem[wr_ptr] <= 32'(in_idx) >= OUTPUT_W;

    assign out_err = out_valid && err_mem[rd_ptr];
`else
    assign out_err = 1'b0;
`endif
endmodule

// File: doc/onehot_decoder_pipe.md
ONEHOT_DECODER_PIPE -- requirements
Module: onehot_decoder_pipe

Interface
REQ-001 SHALL have parameter INPUT_W, default 3, meaning binary index width.
REQ-002 SHALL have parameter OUTPUT_W, default 8, meaning one-hot vector width; legal range is 2**(INPUT_W-1) < OUTPUT_W <= 2**INPUT_W.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1 bit, a synchronous discard of all buffered entries.
REQ-006 SHALL have port in_idx, input, INPUT_W bits, the binary index to decode.
REQ-007 SHALL have port in_valid, input, 1 bit, asserting that in_idx is valid.
REQ-008 SHALL have port in_ready, output, 1 bit, asserting that the block accepts in_idx this cycle.
REQ-009 SHALL have port out_onehot, output, OUTPUT_W bits, the decoded one-hot vector.
REQ-010 SHALL have port out_err, output, 1 bit, flagging that the index at the head entry is out of range.
REQ-011 SHALL have port out_valid, output, 1 bit, asserting that out_onehot and out_err are valid.
REQ-012 SHALL have port out_ready, input, 1 bit, asserting that the consumer accepts the output this cycle.

Function
REQ-013 SHALL transfer input when in_valid&&in_ready at a rising edge; SHALL transfer output when out_valid&&out_ready at a rising edge.
REQ-014 SHALL buffer decoded results in a 2-entry FIFO (head/tail pointer, 2-bit count 0..2); decode occurs before storage.
REQ-015 SHALL compute stored vector as bit in_idx set, all others 0, for in_idx < OUTPUT_W.
REQ-016 SHALL drive in_ready = (count != 2), out_valid = (count != 0); both derived from registered count only, with no combinational path from in_valid/out_ready.
REQ-017 SHALL present out_onehot/out_err from head entry; values SHALL remain stable while out_valid&&!out_ready.
REQ-018 SHALL provide latency of 1: an index accepted at edge k drives out_valid high from edge k onward into cycle k+1 when the FIFO was empty.
REQ-019 SHALL sustain one transfer per cycle when out_ready is held high (count oscillates 0->1 and stays 1).
REQ-020 SHALL, on simultaneous push and pop at count 1, leave count 1 with the new entry at head next cycle.
REQ-021 SHALL, at count 2, deassert in_ready; a pop at count 2 SHALL yield count 1 and in_ready high next cycle.
REQ-022 SHALL wrap pointers modulo 2.
REQ-023 SHALL, when flush is high, set count and pointers to 0 at that edge, ignore any simultaneous push/pop, and leave data contents don't-care.
REQ-024 SHALL give flush lower priority than rst; the two SHALL behave identically on outputs.

Reset
REQ-025 SHALL, when rst is high at an edge, set count=0 and pointers=0, giving in_ready=1, out_valid=0, out_onehot=0, and out_err=0 from the next cycle.
REQ-026 SHALL drop entries in flight when reset occurs mid-transfer; no output handshake SHALL complete in a reset cycle.
REQ-027 SHALL force out_onehot and out_err to 0 whenever out_valid=0.

Configuration
REQ-028 SHALL use macro ONEHOT_DECODER_PIPE_ERR_EN to control range checking.
REQ-029 SHALL, when ONEHOT_DECODER_PIPE_ERR_EN is defined, store an index >= OUTPUT_W as all-zero vector with err bit 1; out_err SHALL mirror the head entry's err bit.
REQ-030 SHALL, when ONEHOT_DECODER_PIPE_ERR_EN is undefined, implement no err storage, tie out_err to 0, and still store an out-of-range index as an all-zero vector.

Verification
REQ-031 SHALL cover reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_onehot=0 after release.
REQ-032 SHALL cover streaming: INPUT_W=3, OUTPUT_W=8, idx 0..7 back-to-back with out_ready=1 -> out_onehot 0x01,0x02,...,0x80 one per cycle, each 1 cycle after acceptance.
REQ-033 SHALL cover backpressure: out_ready=0, push idx 3,5,6 -> 3,5 accepted, in_ready=0 at count 2; then out_ready=1 -> 0x08 then 0x20, then idx 6 accepted -> 0x40.
REQ-034 SHALL cover range check: OUTPUT_W=5, idx 6 -> with macro: out_onehot=0x00, out_err=1; without macro: out_onehot=0x00, out_err=0.
REQ-035 SHALL cover flush: two entries held, flush=1 together with in_valid=1 idx 2 -> out_valid=0 next cycle, idx 2 not stored, in_ready=1.
REQ-036 SHALL cover stability: out_ready toggled randomly -> head values never change while out_valid&&!out_ready, and the order is preserved.
